nonrestoring_divider: RTL and testbench

Sequential signed integer divider computing quotient and remainder of two WIDTH-bit two's-complement operands, one quotient bit per clock (radix-2 non-restoring). It is the inverse counterpart of the sequential radix-4 Booth multiplier in the FloatMultiplier datapath. It serves the floating-point divide path (mantissa division) and integer divide requests, using a start/done handshake.

---
 rtl/nonrestoring_divider_pkg.sv | 26 ++
 rtl/nonrestoring_divider_step.sv | 28 ++
 rtl/nonrestoring_divider.sv | 153 +++++++++++++++
 tb/tb_nonrestoring_divider.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nonrestoring_divider_pkg.sv
// Shared definitions for the sequential radix-2 non-restoring divider.
//   state_t       : controller states
//   DEFAULT_WIDTH : default operand/result width
//   MAX_WIDTH     : widest operand abs_ext accepts (callers sign-extend into it)
//   abs_ext       : two's-complement value -> unsigned magnitude one bit wider
package nonrestoring_divider_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ITER,
    FIX
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned MAX_WIDTH     = 64;

  // The extra result bit keeps |-2^(n-1)| exact. Callers sign-extend a
  // narrower operand to MAX_WIDTH and size-cast the result down to WIDTH+1.
  function automatic logic [MAX_WIDTH:0] abs_ext(input logic [MAX_WIDTH-1:0] v);
    logic [MAX_WIDTH:0] ext;
    ext = {v[MAX_WIDTH-1], v};
    return v[MAX_WIDTH-1] ? -ext : ext;
  endfunction

endpackage

// File: rtl/nonrestoring_divider_step.sv
// One combinational non-restoring iteration.
//   p_in   : signed partial remainder (WIDTH+2 bits)
//   q_msb  : MSB of the quotient/dividend register, shifted into P
//   d_mag  : divisor magnitude (WIDTH+1 bits)
//   p_out  : next partial remainder
//   q_bit  : new quotient LSB (1 when the next remainder is non-negative)
module nr_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH+1:0] p_in,
  input  logic             q_msb,
  input  logic [WIDTH:0]   d_mag,
  output logic [WIDTH+1:0] p_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] p_shift;
  logic [WIDTH+1:0] d_ext;

  always_comb begin
    p_shift = {p_in[WIDTH:0], q_msb};
    d_ext   = {1'b0, d_mag};
    // Sign of the current remainder selects subtract (>=0) or add (<0).
    p_out   = p_in[WIDTH+1] ? (p_shift + d_ext) : (p_shift - d_ext);
    q_bit   = ~p_out[WIDTH+1];
  end

endmodule

// File: rtl/nonrestoring_divider.sv
// Sequential signed divider, one quotient bit per clock (radix-2 non-restoring).
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   start        : request, accepted only while idle
//   dividend     : signed numerator, captured on the accepting edge
//   divisor      : signed denominator, captured on the accepting edge
//   busy         : high from the accepting edge until the result edge
//   done         : one-cycle pulse when results are written
//   quotient     : signed quotient, truncated toward zero
//   remainder    : signed remainder, same sign as the dividend
//   div_by_zero  : last result came from a zero divisor
// Latency: WIDTH+2 edges for a normal result, 1 edge for divide-by-zero.
module nonrestoring_divider
  import nonrestoring_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned MAG_W = WIDTH + 1;

  state_t state, next_state;

  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH+1:0] p_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH:0]   d_mag_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sign_q;
  logic             sign_r;

  logic [WIDTH+1:0] p_next;
  logic             q_bit;
  logic [WIDTH-1:0] rem_mag;
  logic             dvs_zero;

  nr_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .p_in  (p_q),
    .q_msb (q_q[WIDTH-1]),
    .d_mag (d_mag_q),
    .p_out (p_next),
    .q_bit (q_bit)
  );

  always_comb begin
    dvs_zero = (dvs_q == '0);
    // Final restore: a negative partial remainder gets the divisor added back.
    // The corrected value is below |divisor| <= 2^(WIDTH-1), so WIDTH bits hold it.
    rem_mag  = WIDTH'(p_q[WIDTH+1] ? (p_q + {1'b0, d_mag_q}) : p_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = LOAD;
        end
      end
      LOAD: begin
        busy       = 1'b1;
        next_state = dvs_zero ? IDLE : ITER;
      end
      ITER: begin
        busy = 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          next_state = FIX;
        end
      end
      FIX: begin
        busy       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dvd_q       <= '0;
      dvs_q       <= '0;
      p_q         <= '0;
      q_q         <= '0;
      d_mag_q     <= '0;
      cnt_q       <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvd_q <= dividend;
            dvs_q <= divisor;
          end
        end
        LOAD: begin
          sign_q  <= dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1];
          sign_r  <= dvd_q[WIDTH-1];
          p_q     <= '0;
          q_q     <= WIDTH'(abs_ext(MAX_WIDTH'($signed(dvd_q))));
          d_mag_q <= MAG_W'(abs_ext(MAX_WIDTH'($signed(dvs_q))));
          cnt_q   <= '0;
          if (dvs_zero) begin
            quotient    <= '1;
            remainder   <= dvd_q;
            div_by_zero <= 1'b1;
            done        <= 1'b1;
          end
        end
        ITER: begin
          p_q   <= p_next;
          q_q   <= {q_q[WIDTH-2:0], q_bit};
          cnt_q <= cnt_q + CNT_W'(1);
        end
        FIX: begin
          quotient    <= sign_q ? -q_q : q_q;
          remainder   <= sign_r ? -rem_mag : rem_mag;
          div_by_zero <= 1'b0;
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nonrestoring_divider.sv
module tb_nonrestoring_divider;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  nonrestoring_divider #(
    .WIDTH (W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Presents a request and lets it be taken on the next rising edge.
  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges after the accept edge until done is seen (bounded).
  task automatic wait_done(output int n, output int busy_low);
    n        = 0;
    busy_low = 0;
    while (n < 60) begin
      @(posedge clk);
      #1;
      n++;
      if (done) break;
      if (!busy) busy_low++;
    end
  endtask

  task automatic run(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] q, input logic [W-1:0] r, input logic z,
                     input int lat);
    int n, bl;
    accept(a, b);
    check({name, " busy after accept"}, W'(busy), W'(1));
    wait_done(n, bl);
    check({name, " latency"}, W'(n), W'(lat));
    check({name, " busy dropouts"}, W'(bl), W'(0));
    check({name, " quotient"}, quotient, q);
    check({name, " remainder"}, remainder, r);
    check({name, " div_by_zero"}, W'(div_by_zero), W'(z));
    check({name, " busy in done cycle"}, W'(busy), W'(0));
    @(posedge clk);
    #1;
    check({name, " done falls"}, W'(done), W'(0));
  endtask

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic z);
    longint la, lb;
    if (b == '0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else begin
      la = longint'($signed(a));
      lb = longint'($signed(b));
      q  = W'(la / lb);
      r  = W'(la % lb);
      z  = 1'b0;
    end
  endfunction

  initial begin
    int n, bl, nd, de;
    logic [W-1:0] cq, cr, t, a, b, eq, er;
    logic ez;

    vecs[0]  = '{32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 34};
    vecs[1]  = '{32'hFFFFFF9C,  32'd7,         32'hFFFFFFF2,  32'hFFFFFFFE,  1'b0, 34};
    vecs[2]  = '{32'd100,       32'hFFFFFFF9,  32'hFFFFFFF2,  32'd2,         1'b0, 34};
    vecs[3]  = '{32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        32'hFFFFFFFE,  1'b0, 34};
    vecs[4]  = '{32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         1'b0, 34};
    vecs[5]  = '{32'h80000000,  32'd1,         32'h80000000,  32'd0,         1'b0, 34};
    vecs[6]  = '{32'd5,         32'd0,         32'hFFFFFFFF,  32'd5,         1'b1, 1};
    vecs[7]  = '{32'd7,         32'd3,         32'd2,         32'd1,         1'b0, 34};
    vecs[8]  = '{32'd0,         32'd5,         32'd0,         32'd0,         1'b0, 34};
    vecs[9]  = '{32'h7FFFFFFF,  32'h80000000,  32'd0,         32'h7FFFFFFF,  1'b0, 34};
    vecs[10] = '{32'h80000000,  32'h80000000,  32'd1,         32'd0,         1'b0, 34};
    vecs[11] = '{32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0, 34};
    vecs[12] = '{32'h7FFFFFFF,  32'd1,         32'h7FFFFFFF,  32'd0,         1'b0, 34};
    vecs[13] = '{32'h80000000,  32'd0,         32'hFFFFFFFF,  32'h80000000,  1'b1, 1};

    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset busy", W'(busy), W'(0));
    check("reset done", W'(done), W'(0));
    check("reset quotient", quotient, '0);
    check("reset remainder", remainder, '0);
    check("reset div_by_zero", W'(div_by_zero), W'(0));

    for (int i = 0; i < 14; i++) begin
      run($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
          vecs[i].z, vecs[i].lat);
    end

    // Starts at edges 5 and 20 mid-operation must be ignored.
    accept(32'd100, 32'd7);
    nd = 0;
    de = 0;
    cq = '0;
    cr = '0;
    for (int k = 1; k <= 40; k++) begin
      start    = (k == 5 || k == 20);
      dividend = 32'd9;
      divisor  = 32'd3;
      @(posedge clk);
      #1;
      if (done) begin
        nd++;
        de = k;
        cq = quotient;
        cr = remainder;
      end
    end
    start = 1'b0;
    check("ignored-start done count", W'(nd), W'(1));
    check("ignored-start done edge", W'(de), W'(34));
    check("ignored-start quotient", cq, 32'd14);
    check("ignored-start remainder", cr, 32'd2);

    // New request raised during the done cycle is accepted on the next edge.
    accept(32'd20, 32'd6);
    wait_done(n, bl);
    check("b2b first latency", W'(n), W'(34));
    check("b2b first quotient", quotient, 32'd3);
    check("b2b first remainder", remainder, 32'd2);
    accept(32'hFFFFFFCE, 32'd7);
    check("b2b done falls on accept", W'(done), W'(0));
    check("b2b busy on accept", W'(busy), W'(1));
    wait_done(n, bl);
    check("b2b second latency", W'(n), W'(34));
    check("b2b second quotient", quotient, 32'hFFFFFFF9);
    check("b2b second remainder", remainder, 32'hFFFFFFFF);
    @(posedge clk);
    #1;

    // Reset at edge 10, together with a start request, discards the operation.
    accept(32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    reset    = 1'b1;
    start    = 1'b1;
    dividend = 32'd77;
    divisor  = 32'd5;
    @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    check("mid reset busy", W'(busy), W'(0));
    check("mid reset done", W'(done), W'(0));
    check("mid reset quotient", quotient, '0);
    check("mid reset remainder", remainder, '0);
    check("mid reset div_by_zero", W'(div_by_zero), W'(0));
    nd = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) nd++;
    end
    check("mid reset no activity", W'(nd), W'(0));
    run("after reset", 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 34);

    // Random signed pairs against native truncating division.
    for (int i = 0; i < 1500; i++) begin
      a = $urandom;
      if ($urandom_range(0, 31) == 0) a = 32'h80000000;
      case ($urandom_range(0, 3))
        0: begin
          t = $urandom_range(0, 16);
          b = t - 32'd8;
        end
        1: begin
          b = $urandom >> $urandom_range(0, 31);
          if ($urandom_range(0, 1) == 1) b = -b;
        end
        default: b = $urandom;
      endcase
      model(a, b, eq, er, ez);
      accept(a, b);
      wait_done(n, bl);
      check($sformatf("rnd%0d 0x%08h/0x%08h quotient", i, a, b), quotient, eq);
      check($sformatf("rnd%0d 0x%08h/0x%08h remainder", i, a, b), remainder, er);
      check($sformatf("rnd%0d div_by_zero", i), W'(div_by_zero), W'(ez));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
